// File: rtl/pkt_mem_arbiter_if.sv
// Memory-port arbitration bus: per-master request/access signals, one-hot
// grant, the shared memory port and arbiter status.
interface pkt_mem_arbiter_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ADDR_BUS = 32,
  parameter int unsigned DATA_BUS = 32
);
  logic [NUM_REQ-1:0]                req_i;
  logic [NUM_REQ-1:0]                gnt_o;
  logic [NUM_REQ-1:0]                rq_ce_i;
  logic [NUM_REQ-1:0]                rq_we_i;
  logic [NUM_REQ-1:0][ADDR_BUS-1:0]  rq_addr_i;
  logic [NUM_REQ-1:0][3:0]           rq_width_i;
  logic [NUM_REQ-1:0][DATA_BUS-1:0]  rq_data_i;
  logic [DATA_BUS-1:0]               rq_data_o;
  logic                              mem_ce_o;
  logic                              mem_we_o;
  logic [ADDR_BUS-1:0]               mem_addr_o;
  logic [3:0]                        mem_width_o;
  logic [DATA_BUS-1:0]               mem_data_o;
  logic [DATA_BUS-1:0]               mem_data_i;
  logic                              busy_o;
  logic [2:0]                        owner_o;
  logic                              revoke_o;

  // Arbiter side
  modport slave (
    input  req_i, rq_ce_i, rq_we_i, rq_addr_i, rq_width_i, rq_data_i, mem_data_i,
    output gnt_o, rq_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o,
           mem_data_o, busy_o, owner_o, revoke_o
  );

  // Masters plus memory side
  modport master (
    output req_i, rq_ce_i, rq_we_i, rq_addr_i, rq_width_i, rq_data_i, mem_data_i,
    input  gnt_o, rq_data_o, mem_ce_o, mem_we_o, mem_addr_o, mem_width_o,
           mem_data_o, busy_o, owner_o, revoke_o
  );
endinterface

// File: rtl/pkt_mem_arbiter.sv
// Round-robin arbiter sharing one packet/table memory port between NUM_REQ
// masters, with direct owner-to-owner handover and a combinational memory
// mux driven from the registered grant.
// Optional feature: define ARB_HOLD_TIMEOUT_EN to revoke a grant held for
// MAX_HOLD cycles while another master is waiting.
module pkt_mem_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 256,
  parameter int unsigned ADDR_BUS = 32,
  parameter int unsigned DATA_BUS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pkt_mem_arbiter_if.slave      bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Elaboration-time parameter range checks
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("pkt_mem_arbiter: NUM_REQ must be 2..8");
  end
  if (MAX_HOLD < 1) begin : g_bad_max_hold
    $error("pkt_mem_arbiter: MAX_HOLD must be at least 1");
  end

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [2:0]         owner_q, owner_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               revoke_q, revoke_d;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0]  hold_q, hold_d;
`endif

  logic [IDX_W-1:0]   own_idx;
  logic [IDX_W-1:0]   own_inc;
  logic [NUM_REQ-1:0] others;
  logic               owner_req;
  logic               rr_found, ho_found;
  logic [IDX_W-1:0]   rr_idx, ho_idx;

  // First requesting index at or after start, wrapping modulo NUM_REQ
  function automatic logic [IDX_W:0] pick(input logic [NUM_REQ-1:0] r,
                                          input logic [IDX_W-1:0]   start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int unsigned      j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(start) + k) % NUM_REQ;
      if (!found && r[IDX_W'(j)]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  assign own_idx   = IDX_W'(owner_q);
  assign own_inc   = (32'(own_idx) == NUM_REQ - 1) ? '0 : own_idx + IDX_W'(1);
  assign others    = bus.req_i & ~gnt_q;
  assign owner_req = |(bus.req_i & gnt_q);
  assign {rr_found, rr_idx} = pick(bus.req_i, rr_q);
  assign {ho_found, ho_idx} = pick(others, own_inc);

  // State and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      revoke_q <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
      revoke_q <= revoke_d;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_q   <= hold_d;
`endif
    end
  end

  // Next-state: grant from IDLE, hold, release handover, optional revoke
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    revoke_d = 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
    hold_d   = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (rr_found) begin
          state_d = OWNED;
          gnt_d   = NUM_REQ'(1) << rr_idx;
          owner_d = 3'(rr_idx);
          busy_d  = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          gnt_d   = '0;
          owner_d = '0;
          busy_d  = 1'b0;
        end
      end
      OWNED: begin
        if (owner_req) begin
`ifdef ARB_HOLD_TIMEOUT_EN
          if (hold_q == HOLD_W'(MAX_HOLD) && ho_found) begin
            rr_d     = own_inc;
            gnt_d    = NUM_REQ'(1) << ho_idx;
            owner_d  = 3'(ho_idx);
            hold_d   = '0;
            revoke_d = 1'b1;
          end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
            hold_d   = hold_q + HOLD_W'(1);
          end
`endif
        end else begin
          rr_d = own_inc;
          if (ho_found) begin
            gnt_d   = NUM_REQ'(1) << ho_idx;
            owner_d = 3'(ho_idx);
`ifdef ARB_HOLD_TIMEOUT_EN
            hold_d  = '0;
`endif
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            owner_d = '0;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic                mux_ce, mux_we;
  logic [ADDR_BUS-1:0] mux_addr;
  logic [3:0]          mux_width;
  logic [DATA_BUS-1:0] mux_data;

  // AND-OR memory mux from the registered one-hot grant; strobes gated by the owner's request
  always_comb begin
    mux_ce    = 1'b0;
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_width = '0;
    mux_data  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gnt_q[k]) begin
        mux_ce    = mux_ce | (bus.rq_ce_i[k] & bus.req_i[k]);
        mux_we    = mux_we | (bus.rq_we_i[k] & bus.req_i[k]);
        mux_addr  = mux_addr | bus.rq_addr_i[k];
        mux_width = mux_width | bus.rq_width_i[k];
        mux_data  = mux_data | bus.rq_data_i[k];
      end
    end
  end

  assign bus.mem_ce_o    = mux_ce;
  assign bus.mem_we_o    = mux_we;
  assign bus.mem_addr_o  = mux_addr;
  assign bus.mem_width_o = mux_width;
  assign bus.mem_data_o  = mux_data;
  assign bus.rq_data_o   = bus.mem_data_i;
  assign bus.gnt_o       = gnt_q;
  assign bus.busy_o      = busy_q;
  assign bus.owner_o     = owner_q;
  assign bus.revoke_o    = revoke_q;

endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// Directed testbench for pkt_mem_arbiter.
module tb_pkt_mem_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pkt_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_BUS(AW), .DATA_BUS(DW)) bus ();

  pkt_mem_arbiter #(.NUM_REQ(NR), .MAX_HOLD(8), .ADDR_BUS(AW), .DATA_BUS(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Grant must never have more than one bit set
  always @(negedge clk) begin
    if (!rst) chk("onehot", 64'((bus.gnt_o & (bus.gnt_o - 4'd1)) == 4'd0), 64'd1);
  end

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_i      = '0;
    bus.rq_ce_i    = '0;
    bus.rq_we_i    = '0;
    bus.rq_addr_i  = '0;
    bus.rq_width_i = '0;
    bus.rq_data_i  = '0;
    bus.mem_data_i = 32'hA5A5_0000;

    // Reset values
    tick;
    chk("rst_gnt",    64'(bus.gnt_o), 64'h0);
    chk("rst_busy",   64'(bus.busy_o), 64'h0);
    chk("rst_owner",  64'(bus.owner_o), 64'h0);
    chk("rst_revoke", 64'(bus.revoke_o), 64'h0);
    chk("rst_ce",     64'(bus.mem_ce_o), 64'h0);
    chk("rdata",      64'(bus.rq_data_o), 64'hA5A5_0000);
    #3 rst = 1'b0;
    tick;

    // Single master 1 write
    bus.rq_ce_i[1]    = 1'b1;
    bus.rq_we_i[1]    = 1'b1;
    bus.rq_addr_i[1]  = 16'h0040;
    bus.rq_data_i[1]  = 32'hDEAD_BEEF;
    bus.rq_width_i[1] = 4'h4;
    bus.req_i[1]      = 1'b1;
    #1 chk("ungranted_ce", 64'(bus.mem_ce_o), 64'h0);
    tick;
    chk("m1_gnt",   64'(bus.gnt_o), 64'h2);
    chk("m1_owner", 64'(bus.owner_o), 64'h1);
    chk("m1_busy",  64'(bus.busy_o), 64'h1);
    chk("m1_ce",    64'(bus.mem_ce_o), 64'h1);
    chk("m1_we",    64'(bus.mem_we_o), 64'h1);
    chk("m1_addr",  64'(bus.mem_addr_o), 64'h40);
    chk("m1_data",  64'(bus.mem_data_o), 64'hDEAD_BEEF);
    chk("m1_width", 64'(bus.mem_width_o), 64'h4);
    bus.req_i[1] = 1'b0;
    #1 chk("m1_ce_gated", 64'(bus.mem_ce_o), 64'h0);
    tick;
    chk("m1_rel_gnt",  64'(bus.gnt_o), 64'h0);
    chk("m1_rel_busy", 64'(bus.busy_o), 64'h0);
    bus.rq_ce_i[1] = 1'b0;
    bus.rq_we_i[1] = 1'b0;

    // rr=2, requests {0,3} -> 3
    bus.req_i = 4'b1001;
    tick;
    chk("rr2_gnt",   64'(bus.gnt_o), 64'h8);
    chk("rr2_owner", 64'(bus.owner_o), 64'h3);
    bus.rq_ce_i[3]   = 1'b1;
    bus.rq_we_i[3]   = 1'b1;
    bus.rq_addr_i[3] = 16'h0033;
    bus.rq_data_i[3] = 32'h0000_3333;
    bus.rq_ce_i[0]   = 1'b1;
    bus.rq_we_i[0]   = 1'b0;
    bus.rq_addr_i[0] = 16'h0011;
    #1;
    chk("mux_we3",   64'(bus.mem_we_o), 64'h1);
    chk("mux_addr3", 64'(bus.mem_addr_o), 64'h33);
    chk("mux_data3", 64'(bus.mem_data_o), 64'h3333);
    bus.rq_we_i[0] = 1'b1;
    bus.rq_we_i[3] = 1'b0;
    #1;
    chk("mux_we_follow3", 64'(bus.mem_we_o), 64'h0);
    chk("mux_ce3",        64'(bus.mem_ce_o), 64'h1);
    bus.rq_we_i[0] = 1'b0;
    bus.rq_we_i[3] = 1'b1;
    #1 chk("mux_we_back3", 64'(bus.mem_we_o), 64'h1);

    // Handover 3 -> 0 without bubble
    bus.req_i[3] = 1'b0;
    tick;
    chk("ho30_gnt",  64'(bus.gnt_o), 64'h1);
    chk("ho30_busy", 64'(bus.busy_o), 64'h1);
    chk("ho30_addr", 64'(bus.mem_addr_o), 64'h11);

    // Async reset mid-ownership
    #3 rst = 1'b1;
    #1;
    chk("arst_gnt",   64'(bus.gnt_o), 64'h0);
    chk("arst_ce",    64'(bus.mem_ce_o), 64'h0);
    chk("arst_busy",  64'(bus.busy_o), 64'h0);
    chk("arst_owner", 64'(bus.owner_o), 64'h0);
    bus.req_i = 4'b0101;
    #2 rst = 1'b0;
    #1 chk("arst_pre_gnt", 64'(bus.gnt_o), 64'h0);

    // Masters 0 and 2 from reset
    tick;
    chk("m02_gnt0", 64'(bus.gnt_o), 64'h1);
    bus.req_i[0] = 1'b0;
    tick;
    chk("m02_gnt2",  64'(bus.gnt_o), 64'h4);
    chk("m02_busy",  64'(bus.busy_o), 64'h1);
    chk("m02_owner", 64'(bus.owner_o), 64'h2);
    bus.req_i[2] = 1'b0;
    tick;
    chk("m02_idle", 64'(bus.gnt_o), 64'h0);

    // rr now 3: requests {1,3} -> 3, then 1
    bus.req_i = 4'b1010;
    tick;
    chk("rr3_gnt", 64'(bus.gnt_o), 64'h8);
    bus.req_i[3] = 1'b0;
    tick;
    chk("rr3_ho", 64'(bus.gnt_o), 64'h2);
    bus.req_i[1] = 1'b0;
    tick;
    chk("rr3_idle", 64'(bus.gnt_o), 64'h0);

    // Rotation from a fresh reset
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    bus.req_i = 4'b1111;
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("rot_gnt_a", 64'(bus.gnt_o), 64'(4'b0001 << seq[i]));
      chk("rot_owner", 64'(bus.owner_o), 64'(seq[i]));
      tick;
      chk("rot_gnt_b", 64'(bus.gnt_o), 64'(4'b0001 << seq[i]));
      tick;
      chk("rot_gnt_c", 64'(bus.gnt_o), 64'(4'b0001 << seq[i]));
      bus.req_i[seq[i]] = 1'b0;
      tick;
      bus.req_i[seq[i]] = 1'b1;
    end
    chk("rot_end_gnt", 64'(bus.gnt_o), 64'h2);

    // Async reset mid-transfer, then master 2 alone
    bus.rq_ce_i[1] = 1'b1;
    #1 chk("xfer_ce", 64'(bus.mem_ce_o), 64'h1);
    #1 rst = 1'b1;
    #1;
    chk("xfer_rst_gnt", 64'(bus.gnt_o), 64'h0);
    chk("xfer_rst_ce",  64'(bus.mem_ce_o), 64'h0);
    bus.req_i = 4'b0100;
    #1 rst = 1'b0;
    tick;
    chk("xfer_m2_gnt",   64'(bus.gnt_o), 64'h4);
    chk("xfer_m2_owner", 64'(bus.owner_o), 64'h2);

    // Hold behaviour: master 0 holds while master 1 waits
    bus.req_i = 4'b0000;
    tick;
    chk("hold_idle", 64'(bus.gnt_o), 64'h0);
    bus.req_i = 4'b0001;
    tick;
    chk("hold_gnt0", 64'(bus.gnt_o), 64'h1);
    bus.req_i[1] = 1'b1;
`ifdef ARB_HOLD_TIMEOUT_EN
    repeat (8) begin
      tick;
      chk("to_hold_gnt",    64'(bus.gnt_o), 64'h1);
      chk("to_hold_revoke", 64'(bus.revoke_o), 64'h0);
    end
    tick;
    chk("to_revoke", 64'(bus.revoke_o), 64'h1);
    chk("to_gnt1",   64'(bus.gnt_o), 64'h2);
    bus.req_i[0] = 1'b0;
    tick;
    chk("to_revoke_end", 64'(bus.revoke_o), 64'h0);
    chk("to_gnt1_kept",  64'(bus.gnt_o), 64'h2);
`else
    repeat (100) begin
      tick;
      chk("nto_gnt",    64'(bus.gnt_o), 64'h1);
      chk("nto_revoke", 64'(bus.revoke_o), 64'h0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
